serv_immenc: RTL



---
 rtl/serv_immenc.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serv_immenc.sv
// Bit-serial immediate encoder: collects a 32-bit immediate LSB first, then
// assembles an RV32I instruction word in the requested format.
//
// state | meaning
// IDLE  | waiting for i_start; fields captured on start
// SHIFT | accepting immediate bits while i_imm_en is high
// DONE  | o_insn presented, held until i_ready
module serv_immenc #(
    parameter bit WITH_ERR_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd_addr,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_imm_en,
    input  logic        i_imm,
    output logic        o_busy,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_insn,
    output logic        o_imm_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] imm_q, imm_d;
    logic [2:0]  fmt_q, fmt_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;

    logic [31:0] insn_enc;
    logic        err_raw;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        imm_d    = imm_q;
        fmt_d    = fmt_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    fmt_d    = i_fmt;
                    opcode_d = i_opcode;
                    funct3_d = i_funct3;
                    funct7_d = i_funct7;
                    rd_d     = i_rd_addr;
                    rs1_d    = i_rs1_addr;
                    rs2_d    = i_rs2_addr;
                    cnt_d    = 5'd0;
                    imm_d    = 32'd0;
                    // R and the two illegal codes carry no immediate
                    state_d  = (i_fmt == FMT_R || i_fmt > FMT_J) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (i_imm_en) begin
                    imm_d = {i_imm, imm_q[31:1]};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            imm_q    <= 32'd0;
            fmt_q    <= 3'd0;
            opcode_q <= 7'd0;
            funct3_q <= 3'd0;
            funct7_q <= 7'd0;
            rd_q     <= 5'd0;
            rs1_q    <= 5'd0;
            rs2_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            imm_q    <= imm_d;
            fmt_q    <= fmt_d;
            opcode_q <= opcode_d;
            funct3_q <= funct3_d;
            funct7_q <= funct7_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
        end
    end

    always_comb begin
        insn_enc = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
        err_raw  = 1'b0;
        case (fmt_q)
            FMT_R: begin
                insn_enc = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
                err_raw  = 1'b0;
            end
            FMT_I: begin
                insn_enc = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
                err_raw  = !((&imm_q[31:11]) || !(|imm_q[31:11]));
            end
            FMT_S: begin
                insn_enc = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
                err_raw  = !((&imm_q[31:11]) || !(|imm_q[31:11]));
            end
            FMT_B: begin
                insn_enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                            imm_q[4:1], imm_q[11], opcode_q};
                err_raw  = imm_q[0] || !((&imm_q[31:12]) || !(|imm_q[31:12]));
            end
            FMT_U: begin
                insn_enc = {imm_q[31:12], rd_q, opcode_q};
                err_raw  = |imm_q[11:0];
            end
            FMT_J: begin
                insn_enc = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
                err_raw  = imm_q[0] || !((&imm_q[31:20]) || !(|imm_q[31:20]));
            end
            default: begin
                insn_enc = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
                err_raw  = 1'b1;
            end
        endcase
    end

    assign o_busy    = (state_q != IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_insn    = o_valid ? insn_enc : 32'd0;
    assign o_imm_err = o_valid & err_raw & WITH_ERR_CHECK;

endmodule
